pulse_fire_sched: RTL and testbench

PULSE_FIRE_SCHED -- requirements
Module: pulse_fire_sched

---
 rtl/pulse_seq_pkg.sv | 19 +
 rtl/pulse_rr_arb.sv | 34 +++
 rtl/pulse_fire_sched.sv | 143 ++++++++++++++
 tb/tb_pulse_fire_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the pulse firing scheduler.
// ST_FAULT only exists when PULSE_FIRE_SCHED_WDOG_EN is defined.
package pulse_seq_pkg;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned WDOG_MAX_DEF = 32'h0000_FFF0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
`ifdef PULSE_FIRE_SCHED_WDOG_EN
    ST_GAP   = 2'd2,
    ST_FAULT = 2'd3
`else
    ST_GAP   = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/pulse_rr_arb.sv
// Combinational round-robin arbiter: first pending channel at or after rr_ptr wins.
module pulse_rr_arb #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         pending,
  input  logic [$clog2(N_CH)-1:0] rr_ptr,
  output logic [N_CH-1:0]         grant,
  output logic [$clog2(N_CH)-1:0] idx,
  output logic                    valid
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  int unsigned      ch;
  logic [IDX_W-1:0] ch_idx;

  always_comb begin
    grant  = '0;
    idx    = '0;
    valid  = 1'b0;
    ch     = 0;
    ch_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch     = (32'(rr_ptr) + i) % N_CH;
      ch_idx = ch[IDX_W-1:0];
      if (!valid && pending[ch_idx]) begin
        valid         = 1'b1;
        grant[ch_idx] = 1'b1;
        idx           = ch_idx;
      end
    end
  end

endmodule

// File: rtl/pulse_fire_sched.sv
// Shared pyro firing driver: round-robin scheduling of one pulse at a time with recharge gap.
// Define PULSE_FIRE_SCHED_WDOG_EN to add the fire-time watchdog and the latched FAULT state.
module pulse_fire_sched
  import pulse_seq_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [N_CH-1:0]         req,
  input  logic [CNT_W-1:0]        pulse_width,
  input  logic [CNT_W-1:0]        gap_cycles,
  output logic [N_CH-1:0]         fire_out,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic                    busy,
  output logic                    done,
  output logic                    fault
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  if (N_CH < 2 || WDOG_MAX < 2) begin : g_param_check
    $error("pulse_fire_sched: N_CH and WDOG_MAX must be at least 2");
  end

  state_t            state_q, state_d;
  logic [N_CH-1:0]   pending_q, grant_clr;
  logic [IDX_W-1:0]  rr_ptr_q, grant_id_q;
  logic [N_CH-1:0]   arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [CNT_W-1:0]  cnt_q, gap_q;
  logic [N_CH-1:0]   fire_q, fire_d;
  logic              done_q, done_d;
  logic              halt, cnt_last, grant_take, clear_all, wdog_trip;

  pulse_rr_arb #(.N_CH(N_CH)) u_arb (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .valid   (arb_valid)
  );

  assign halt     = abort || !arm;
  assign cnt_last = (cnt_q <= CNT_W'(1));

`ifdef PULSE_FIRE_SCHED_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_MAX + 1);
  logic [WD_W-1:0] wdog_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wdog_q <= '0;
    end else if (fire_q == '0) begin
      wdog_q <= '0;
    end else if (wdog_q < WD_W'(WDOG_MAX)) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  // wdog_q counts completed high cycles, so the trip edge ends cycle WDOG_MAX
  assign wdog_trip = (state_q == ST_FIRE) && (|fire_q) && (wdog_q >= WD_W'(WDOG_MAX - 1));
  assign fault     = (state_q == ST_FAULT);
`else
  assign wdog_trip = 1'b0;
  assign fault     = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arm && !abort && arb_valid) state_d = ST_FIRE;
      ST_FIRE: begin
        if (halt)          state_d = ST_IDLE;
        else if (cnt_last) state_d = (gap_q == '0) ? ST_IDLE : ST_GAP;
`ifdef PULSE_FIRE_SCHED_WDOG_EN
        if (wdog_trip)     state_d = ST_FAULT;
`endif
      end
      ST_GAP:  if (halt || cnt_last) state_d = ST_IDLE;
`ifdef PULSE_FIRE_SCHED_WDOG_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    grant_take = (state_q == ST_IDLE) && (state_d == ST_FIRE);
    done_d     = (state_q == ST_FIRE) && cnt_last && !halt && !wdog_trip;
    clear_all  = abort || ((state_q != ST_IDLE) && !arm);
`ifdef PULSE_FIRE_SCHED_WDOG_EN
    if (state_q == ST_FAULT || state_d == ST_FAULT) clear_all = 1'b1;
`endif
    grant_clr = grant_take ? arb_grant : '0;
    fire_d    = '0;
    if (grant_take)                                     fire_d = arb_grant;
    else if (state_q == ST_FIRE && state_d == ST_FIRE) fire_d = fire_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      fire_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      fire_q <= fire_d;
      done_q <= done_d;
      // a new request wins over the clear of the channel being granted
      pending_q <= clear_all ? '0 : ((pending_q & ~grant_clr) | req);
      if (grant_take) begin
        grant_id_q <= arb_idx;
        rr_ptr_q   <= (arb_idx == IDX_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
        cnt_q      <= (pulse_width == '0) ? CNT_W'(1) : pulse_width;
        gap_q      <= gap_cycles;
      end else if (state_q == ST_FIRE && state_d == ST_GAP) begin
        cnt_q <= gap_q;
      end else if ((state_q == ST_FIRE || state_q == ST_GAP) && !cnt_last) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign fire_out = fire_q;
  assign done     = done_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_pulse_fire_sched.sv
// Directed bench for pulse_fire_sched: cycle tables plus hand-written corner sequences.
module tb_pulse_fire_sched;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] pulse_width = '0;
  logic [15:0] gap_cycles = '0;
  logic [3:0]  fire_out;
  logic [1:0]  grant_id;
  logic        busy, done, fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        arm;
    logic [3:0]  req;
    logic [15:0] pw;
    logic [15:0] gap;
    logic [3:0]  e_fire;
    logic        e_busy;
    logic        e_done;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t tbl[$];

  always #5 ACLK = ~ACLK;

  pulse_fire_sched #(.N_CH(4), .CNT_W(16), .WDOG_MAX(50)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .arm         (arm),
    .abort       (abort),
    .req         (req),
    .pulse_width (pulse_width),
    .gap_cycles  (gap_cycles),
    .fire_out    (fire_out),
    .grant_id    (grant_id),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  function automatic vec_t mk(input logic rst, input logic a, input logic [3:0] r,
                              input logic [15:0] pw, input logic [15:0] gp,
                              input logic [3:0] ef, input logic eb, input logic ed,
                              input logic [1:0] eg);
    vec_t v;
    v.rst = rst; v.arm = a; v.req = r; v.pw = pw; v.gap = gp;
    v.e_fire = ef; v.e_busy = eb; v.e_done = ed; v.e_gid = eg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    req     = '0;
    abort   = 1'b0;
    #2;
    ARESETN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int guard;
    logic seen;

    #1;
    check("rst_fire", 32'(fire_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_fault", 32'(fault), 0);

    // single pulse, width 5, gap 3
    tbl.push_back(mk(1, 1, 4'b0001, 5, 3, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 5, 3, 4'b0001, 1, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 4'b0000, 5, 3, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 5, 3, 4'b0000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 5, 3, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 5, 3, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 5, 3, 4'b0000, 0, 0, 0));
    // all four channels at once, width 2, gap 1
    tbl.push_back(mk(1, 1, 4'b1111, 2, 1, 4'b0000, 0, 0, 0));
    for (int c = 0; c < 4; c++) begin
      logic [3:0] oh;
      oh = 4'b0001 << c;
      tbl.push_back(mk(0, 1, 4'b0000, 2, 1, oh, 1, 0, 2'(c)));
      tbl.push_back(mk(0, 1, 4'b0000, 2, 1, oh, 1, 0, 2'(c)));
      tbl.push_back(mk(0, 1, 4'b0000, 2, 1, 4'b0000, 1, 1, 2'(c)));
      tbl.push_back(mk(0, 1, 4'b0000, 2, 1, 4'b0000, 0, 0, 2'(c)));
    end
    // width 0 acts as 1, gap 0 returns straight to idle, re-request at grant survives
    tbl.push_back(mk(1, 1, 4'b0001, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));

    @(negedge ACLK);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      arm         = tbl[i].arm;
      req         = tbl[i].req;
      pulse_width = tbl[i].pw;
      gap_cycles  = tbl[i].gap;
      step();
      check($sformatf("row%0d_fire", i), 32'(fire_out), 32'(tbl[i].e_fire));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      check($sformatf("row%0d_gid", i), 32'(grant_id), 32'(tbl[i].e_gid));
    end

    // abort during a long ch2 pulse, with ch0 pending behind it
    do_reset();
    arm = 1'b1; pulse_width = 100; gap_cycles = 3; req = 4'b0100;
    step();
    req = '0;
    step();
    check("abort_pre_fire", 32'(fire_out), 32'h4);
    for (int i = 0; i < 9; i++) begin
      req = (i == 3) ? 4'b0001 : 4'b0000;
      step();
    end
    req = '0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_fire", 32'(fire_out), 0);
    check("abort_done", 32'(done), 0);
    check("abort_busy", 32'(busy), 0);
    seen = 1'b0;
    repeat (4) begin
      step();
      if (fire_out != 0 || done) seen = 1'b1;
    end
    check("abort_pending_cleared", 32'(seen), 0);

    // request while disarmed waits for arm
    do_reset();
    arm = 1'b0; pulse_width = 4; gap_cycles = 0; req = 4'b0010;
    step();
    req = '0;
    seen = 1'b0;
    repeat (20) begin
      step();
      if (fire_out != 0) seen = 1'b1;
    end
    check("disarmed_no_fire", 32'(seen), 0);
    arm = 1'b1;
    step();
    check("arm_fire", 32'(fire_out), 32'h2);
    check("arm_gid", 32'(grant_id), 1);

    // asynchronous reset mid-pulse
    do_reset();
    arm = 1'b1; pulse_width = 50; gap_cycles = 0; req = 4'b1000;
    step();
    req = 4'b0001;
    step();
    req = '0;
    check("prereset_fire", 32'(fire_out), 32'h8);
    check("prereset_gid", 32'(grant_id), 3);
    @(posedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_fire", 32'(fire_out), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_gid", 32'(grant_id), 0);
    check("async_rst_fault", 32'(fault), 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) step();
    check("postrst_fire", 32'(fire_out), 0);
    check("postrst_busy", 32'(busy), 0);

    // long pulse against the watchdog
    do_reset();
    arm = 1'b1; pulse_width = 200; gap_cycles = 0; req = 4'b0001;
    step();
    req = '0;
    guard = 0;
    while (!fire_out[0] && guard < 10) begin
      step();
      guard++;
    end
    n = 0;
    while (fire_out[0] && n < 400) begin
      n++;
      step();
    end
`ifdef PULSE_FIRE_SCHED_WDOG_EN
    check("wdog_high_cycles", 32'(n), 50);
    check("wdog_fault", 32'(fault), 1);
    check("wdog_done", 32'(done), 0);
    check("wdog_busy", 32'(busy), 1);
    req = 4'b0001;
    step();
    req = '0;
    repeat (5) step();
    check("fault_hold_fire", 32'(fire_out), 0);
    check("fault_hold", 32'(fault), 1);
    do_reset();
    #1;
    check("fault_reset", 32'(fault), 0);
`else
    check("long_high_cycles", 32'(n), 200);
    check("long_done", 32'(done), 1);
    check("long_fault", 32'(fault), 0);
    check("long_busy", 32'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
